fp_cmp_issue: RTL and testbench

- Initiator-side front end for the fixed-latency, non-stallable 32-bit floating-point compare unit, which uses a go-token in and a done-token out.
- Accepts compare requests on a valid/ready stream and drives the unit's go token and operands.
- Captures done tokens and 3-bit results into a result FIFO, presented as a valid/ready response stream.
- Credit accounting guarantees the FIFO never overflows, since the unit cannot be back-pressured.

---
 rtl/fp_cmp_issue.sv | 159 +++++++++++++++
 tb/tb_fp_cmp_issue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/fp_cmp_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fp_cmp_issue
// Brief    : Initiator front end for a fixed-latency, non-stallable FP compare
//            unit; credit-protected result FIFO behind a valid/ready response.
// Revision : 1.0
// ============================================================================
module fp_cmp_issue #(
    parameter int TAG_WIDTH = 4,
    parameter int LATENCY   = 3,
    parameter int DEPTH     = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [TAG_WIDTH-1:0] req_tag,
    input  logic [31:0]          req_a,
    input  logic [31:0]          req_b,
    output logic [TAG_WIDTH:0]   unit_go,
    output logic [31:0]          unit_a,
    output logic [31:0]          unit_b,
    input  logic [TAG_WIDTH:0]   unit_done,
    input  logic [2:0]           unit_result,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [TAG_WIDTH-1:0] resp_tag,
    output logic [2:0]           resp_result,
    output logic                 idle,
    output logic                 overflow_err
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam int c_DW = $clog2(LATENCY + 2);
    localparam int c_EW = TAG_WIDTH + 3;

    localparam logic [c_CW-1:0] c_CRED_INIT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_CRED_ONE  = c_CW'(1);
    localparam logic [c_DW-1:0] c_DRAIN_INIT = c_DW'(LATENCY + 1);
    localparam logic [c_DW-1:0] c_DRAIN_ONE  = c_DW'(1);
    localparam logic [c_AW:0]   c_PTR_ONE   = (c_AW+1)'(1);

    localparam logic [0:0] c_S_DRAIN = 1'b0;
    localparam logic [0:0] c_S_RUN   = 1'b1;

    logic [0:0]           r_state;
    logic [c_DW-1:0]      r_drain_cnt;
    logic [c_CW-1:0]      r_credits;
    logic [c_AW:0]        r_wr_ptr;
    logic [c_AW:0]        r_rd_ptr;
    logic [c_EW-1:0]      r_mem [DEPTH];
    logic [TAG_WIDTH:0]   r_unit_go;
    logic [31:0]          r_unit_a;
    logic [31:0]          r_unit_b;
    logic                 r_overflow;

    logic                 w_run;
    logic                 w_accept;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push_req;
    logic                 w_push;
    logic                 w_drop;
    logic [c_EW-1:0]      w_head;

    assign w_run      = (r_state == c_S_RUN);
    assign req_ready  = w_run && (r_credits != '0);
    assign w_accept   = req_valid && req_ready;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop      = resp_valid && resp_ready;

    // A full FIFO can still take a push when the head leaves on the same edge.
    assign w_push_req = w_run && unit_done[0];
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    assign w_head      = r_mem[r_rd_ptr[c_AW-1:0]];
    assign resp_valid  = !w_empty;
    assign resp_tag    = w_head[c_EW-1:3];
    assign resp_result = w_head[2:0];

    assign unit_go      = r_unit_go;
    assign unit_a       = r_unit_a;
    assign unit_b       = r_unit_b;
    assign overflow_err = r_overflow;
    assign idle         = w_run && (r_credits == c_CRED_INIT) && w_empty;

    // DRAIN flushes tokens left inside the unit, which has no reset of its own.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_S_DRAIN;
            r_drain_cnt <= c_DRAIN_INIT;
        end else if (r_state == c_S_DRAIN) begin
            r_drain_cnt <= r_drain_cnt - c_DRAIN_ONE;
            if (r_drain_cnt == c_DRAIN_ONE) begin
                r_state <= c_S_RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_unit_go <= '0;
            r_unit_a  <= '0;
            r_unit_b  <= '0;
        end else if (w_accept) begin
            r_unit_go <= {req_tag, 1'b1};
            r_unit_a  <= req_a;
            r_unit_b  <= req_b;
        end else begin
            r_unit_go <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_credits <= c_CRED_INIT;
        end else begin
            case ({w_accept, w_pop})
                2'b10:   r_credits <= r_credits - c_CRED_ONE;
                2'b01:   r_credits <= r_credits + c_CRED_ONE;
                default: r_credits <= r_credits;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage is data-only; validity is carried entirely by the pointers.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= {unit_done[TAG_WIDTH:1], unit_result};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_cmp_issue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fp_cmp_issue
// Brief    : Directed self-checking bench for fp_cmp_issue with a compare-unit
//            model that has no reset, as the real unit.
// Revision : 1.0
// ============================================================================
module tb_fp_cmp_issue;

    localparam int TW  = 4;
    localparam int LAT = 3;
    localparam int DEP = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [TW-1:0] req_tag = '0;
    logic [31:0]   req_a = '0;
    logic [31:0]   req_b = '0;
    logic [TW:0]   unit_go;
    logic [31:0]   unit_a;
    logic [31:0]   unit_b;
    logic [TW:0]   unit_done;
    logic [2:0]    unit_result;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [TW-1:0] resp_tag;
    logic [2:0]    resp_result;
    logic          idle;
    logic          overflow_err;

    logic [TW:0]   inj_tok = '0;
    logic [TW:0]   pipe_tok [LAT];
    logic [2:0]    pipe_res [LAT];

    int n_cmp = 0;
    int n_err = 0;
    int acc_cnt = 0;
    int rcv_cnt = 0;
    int both_cnt = 0;
    int used_cyc = 0;
    logic [6:0] sb_q [$];

    always #5 clock = ~clock;

    fp_cmp_issue #(.TAG_WIDTH(TW), .LATENCY(LAT), .DEPTH(DEP)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_a(req_a), .req_b(req_b),
        .unit_go(unit_go), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_result(unit_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_tag(resp_tag), .resp_result(resp_result),
        .idle(idle), .overflow_err(overflow_err)
    );

    // Unit result: one-hot {a<b, a==b, a>b} on the raw bit patterns.
    function automatic logic [2:0] exp_res(input logic [31:0] a, input logic [31:0] b);
        if (a < b)       return 3'b100;
        else if (a == b) return 3'b010;
        else             return 3'b001;
    endfunction

    always_ff @(posedge clock) begin
        pipe_tok[0] <= unit_go;
        pipe_res[0] <= exp_res(unit_a, unit_b);
        for (int i = 1; i < LAT; i++) begin
            pipe_tok[i] <= pipe_tok[i-1];
            pipe_res[i] <= pipe_res[i-1];
        end
    end
    assign unit_done   = pipe_tok[LAT-1] | inj_tok;
    assign unit_result = pipe_res[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called and returns on a falling edge; requests carry tag/a = acc_cnt, b = 50.
    task automatic traffic(input int n_total, input logic rr, input int cycles);
        logic [6:0] e;
        resp_ready = rr;
        used_cyc = cycles;
        for (int c = 0; c < cycles; c++) begin
            req_valid = (acc_cnt < n_total);
            req_tag   = acc_cnt[TW-1:0];
            req_a     = 32'(acc_cnt);
            req_b     = 32'd50;
            #1;
            if (req_valid && req_ready && resp_valid && resp_ready) both_cnt++;
            if (req_valid && req_ready) begin
                sb_q.push_back({req_tag, exp_res(req_a, req_b)});
                acc_cnt++;
            end
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("resp_unexpected", 64'(1), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_tag_order", 64'(resp_tag), 64'(e[6:3]));
                    chk("resp_result", 64'(resp_result), 64'(e[2:0]));
                end
                rcv_cnt++;
            end
            @(negedge clock);
            if (rr && acc_cnt >= n_total && sb_q.size() == 0) begin
                used_cyc = c + 1;
                break;
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int lat;
        int seen;

        // Reset values
        repeat (5) @(negedge clock);
        chk("rst_unit_go", 64'(unit_go), 64'(0));
        chk("rst_unit_ab", 64'({unit_a, unit_b}), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_overflow", 64'(overflow_err), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_idle", 64'(idle), 64'(0));

        // Drain window after release with req_valid held; spurious done injected
        reset_n   = 1'b1;
        req_valid = 1'b1;
        n = 0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            inj_tok = (n == 1) ? {4'hA, 1'b1} : '0;
            #1;
            if (req_ready) break;
            n++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        inj_tok   = '0;
        chk("drain_cycles", 64'(n), 64'(LAT + 1));
        for (int i = 0; i < 4; i++) begin
            if (resp_valid) seen++;
            @(negedge clock);
        end
        chk("drain_spurious_dropped", 64'(seen), 64'(0));
        chk("idle_after_drain", 64'(idle), 64'(1));

        // Single request, tag 5, 1.0 vs 2.0
        req_valid = 1'b1; req_tag = 4'd5; req_a = 32'h3F80_0000; req_b = 32'h4000_0000;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) break;
            @(negedge clock);
        end
        chk("single_ready", 64'(req_ready), 64'(1));
        @(negedge clock);
        req_valid = 1'b0;
        chk("single_go", 64'(unit_go), 64'({4'd5, 1'b1}));
        chk("single_ab", 64'({unit_a, unit_b}), {32'h3F80_0000, 32'h4000_0000});
        chk("single_busy", 64'(idle), 64'(0));
        @(negedge clock);
        chk("single_go_clear", 64'(unit_go), 64'(0));
        chk("single_a_hold", 64'(unit_a), 64'(32'h3F80_0000));
        lat = 2;
        while (!resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk("single_latency", 64'(lat), 64'(5));
        chk("single_tag", 64'(resp_tag), 64'(5));
        chk("single_result", 64'(resp_result), 64'(3'b100));
        resp_ready = 1'b1;
        @(negedge clock);
        resp_ready = 1'b0;
        chk("single_popped", 64'(resp_valid), 64'(0));
        chk("single_idle", 64'(idle), 64'(1));

        // Burst of 6 with consumer stalled: credits cap at 4
        acc_cnt = 0; rcv_cnt = 0;
        traffic(6, 1'b0, 15);
        chk("burst_accepts", 64'(acc_cnt), 64'(4));
        chk("burst_ready_low", 64'(req_ready), 64'(0));
        chk("burst_head_valid", 64'(resp_valid), 64'(1));
        chk("burst_head_tag", 64'(resp_tag), 64'(0));
        chk("burst_no_overflow", 64'(overflow_err), 64'(0));
        traffic(6, 1'b1, 60);
        chk("burst_total_acc", 64'(acc_cnt), 64'(6));
        chk("burst_total_rcv", 64'(rcv_cnt), 64'(6));
        chk("burst_idle", 64'(idle), 64'(1));

        // Continuous 100-request stream
        both_cnt = 0; rcv_cnt = 0;
        traffic(acc_cnt + 100, 1'b1, 400);
        chk("stream_acc", 64'(acc_cnt), 64'(106));
        chk("stream_rcv", 64'(rcv_cnt), 64'(100));
        chk("stream_overlap", 64'(both_cnt > 0), 64'(1));
        chk("stream_throughput", 64'(used_cyc <= 160), 64'(1));
        chk("stream_no_overflow", 64'(overflow_err), 64'(0));
        chk("stream_idle", 64'(idle), 64'(1));

        // Reset pulse with requests in flight
        traffic(acc_cnt + 3, 1'b0, 3);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_unit_go", 64'(unit_go), 64'(0));
        chk("midrst_unit_ab", 64'({unit_a, unit_b}), 64'(0));
        chk("midrst_req_ready", 64'(req_ready), 64'(0));
        chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
        #1 reset_n = 1'b1;
        sb_q.delete();
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (resp_valid) seen++;
        end
        chk("midrst_late_dropped", 64'(seen), 64'(0));
        chk("midrst_ready", 64'(req_ready), 64'(1));
        chk("midrst_idle", 64'(idle), 64'(1));
        chk("midrst_overflow", 64'(overflow_err), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
